// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports and the data-memory port of dmem_arbiter.
//   slave  : the arbiter side (samples requests, drives grants and memory strobes)
//   master : the requesters plus the memory (drive requests and mem_rdata)
//   Requester signals : req0/1, we0/1, addr0/1, wdata0/1  -> arbiter
//   Grant/response    : gnt0/1, err0/1, rvalid0/1, rdata   <- arbiter
//   Memory port       : mem_read, mem_write, mem_addr, mem_wdata <- arbiter, mem_rdata -> arbiter
interface dmem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic             req1;
    logic             we0;
    logic             we1;
    logic [WIDTH-1:0] addr0;
    logic [WIDTH-1:0] addr1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic             gnt0;
    logic             gnt1;
    logic             err0;
    logic             err1;
    logic             rvalid0;
    logic             rvalid1;
    logic [WIDTH-1:0] rdata;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, err0, err1, rvalid0, rvalid1, rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, err0, err1, rvalid0, rvalid1, rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter and sequencer sharing one data-memory port between
//   port 0 (load/store unit) and port 1 (DMA/test loader). One memory command
//   per accepted request; reads return one cycle after the command because the
//   memory registers its read data. Out-of-range addresses are acknowledged
//   with gnt+err and never reach the memory.
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     reset : asynchronous, active-high
//     bus   : dmem_arbiter_if.slave (requests, grants, read return, memory port)
//
//   state | meaning
//   IDLE  | waiting for a request; arbitration happens on the edge leaving IDLE
//   CMD   | gnt (and err or one memory strobe) for the owner
//   RESP  | memory read data is on mem_rdata; rvalid for the owner
module dmem_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             err0_q, err0_d;
    logic             err1_q, err1_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Arbitration: a lone requester wins; on a tie the port that was not
    // granted last time wins.
    logic             win;
    logic             sel_we;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             sel_err;

    assign win       = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
    assign sel_we    = win ? bus.we1    : bus.we0;
    assign sel_addr  = win ? bus.addr1  : bus.addr0;
    assign sel_wdata = win ? bus.wdata1 : bus.wdata0;
    assign sel_err   = (sel_addr >= WIDTH'(DEPTH));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d      = win;
                    last_grant_d = win;
                    mem_addr_d   = sel_addr;
                    mem_wdata_d  = sel_wdata;
                    gnt0_d       = ~win;
                    gnt1_d       = win;
                    err0_d       = sel_err & ~win;
                    err1_d       = sel_err & win;
                    mem_read_d   = ~sel_err & ~sel_we;
                    mem_write_d  = ~sel_err & sel_we;
                    state_d      = CMD;
                end
            end
            CMD: begin
                // Only an issued read needs the response cycle.
                if (mem_read_q) begin
                    rvalid0_d = ~owner_q;
                    rvalid1_d = owner_q;
                    state_d   = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                rdata_d = bus.mem_rdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.err0      = err0_q;
    assign bus.err1      = err1_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    // The memory's registered read data is only valid during RESP, so it is
    // passed straight through then and held afterwards.
    assign bus.rdata     = (rvalid0_q | rvalid1_q) ? bus.mem_rdata : rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    localparam int W = 32;
    localparam int D = 512;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.WIDTH(W)) bus ();
    dmem_arbiter #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Data memory behind the arbiter: one-cycle registered read.
    logic [31:0] mem [0:D-1];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < D; i++) mem[i] <= '0;
            bus.mem_rdata <= '0;
        end else begin
            if (bus.mem_write) mem[bus.mem_addr[8:0]] <= bus.mem_wdata;
            if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[8:0]];
        end
    end

    // Transaction-level reference: when the arbiter is free at an edge and
    // someone requests, the winner's command shows in the next cycle and a
    // read's data in the cycle after; the arbiter is free again 2 edges later
    // (write/reject) or 3 edges later (read).
    typedef struct packed {
        logic g0, g1, e0, e1, v0, v1, mr, mw;
        logic cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        slot [0:7];
    logic [31:0] ref_mem [0:D-1];
    int          cyc = 0;
    int          next_free;
    int          m_p;
    logic        last_g;
    logic        m_we;
    logic        m_bad;
    logic [31:0] m_a, m_wd;
    exp_t        m_e, m_r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) slot[i] = '0;
            for (int i = 0; i < D; i++) ref_mem[i] = '0;
            next_free = 0;
            last_g = 1'b1;
        end else begin
            cyc = cyc + 1;
            slot[(cyc + 2) % 8] = '0;
            if (cyc >= next_free && (bus.req0 || bus.req1)) begin
                if (bus.req0 && bus.req1) m_p = last_g ? 0 : 1;
                else m_p = bus.req1 ? 1 : 0;
                last_g = (m_p == 1);
                m_we  = (m_p == 1) ? bus.we1 : bus.we0;
                m_a   = (m_p == 1) ? bus.addr1 : bus.addr0;
                m_wd  = (m_p == 1) ? bus.wdata1 : bus.wdata0;
                m_bad = (m_a >= D);
                m_e = '0;
                m_e.cmd = 1'b1;
                m_e.addr = m_a;
                m_e.wdata = m_wd;
                m_e.g0 = (m_p == 0);
                m_e.g1 = (m_p == 1);
                if (m_bad) begin
                    m_e.e0 = (m_p == 0);
                    m_e.e1 = (m_p == 1);
                    next_free = cyc + 2;
                end else if (m_we) begin
                    m_e.mw = 1'b1;
                    ref_mem[m_a[8:0]] = m_wd;
                    next_free = cyc + 2;
                end else begin
                    m_e.mr = 1'b1;
                    m_r = '0;
                    m_r.v0 = (m_p == 0);
                    m_r.v1 = (m_p == 1);
                    m_r.rdata = ref_mem[m_a[8:0]];
                    slot[(cyc + 1) % 8] = m_r;
                    next_free = cyc + 3;
                end
                slot[cyc % 8] = m_e;
            end
        end
    end

    int   n_checks = 0;
    int   n_errors = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {24'd0, bus.gnt0, bus.gnt1, bus.err0, bus.err1,
                bus.rvalid0, bus.rvalid1, bus.mem_read, bus.mem_write};
    endfunction

    // Advance to the next falling edge and compare every output with the model.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (chk_on) begin
            e = slot[cyc % 8];
            chk("cycle_strobes", strobes(),
                {24'd0, e.g0, e.g1, e.e0, e.e1, e.v0, e.v1, e.mr, e.mw});
            if (e.cmd) begin
                chk("cycle_mem_addr", bus.mem_addr, e.addr);
                chk("cycle_mem_wdata", bus.mem_wdata, e.wdata);
            end
            if (e.v0 || e.v1) chk("cycle_rdata", bus.rdata, e.rdata);
        end
    endtask

    task automatic set_req(input int p, input logic r, input logic we,
                           input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
        end
    endtask

    task automatic do_txn(input int p, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic got_err,
                          output logic got_mw, output logic got_rv, output logic [31:0] got_rd);
        set_req(p, 1'b1, we, a, wd);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!((p == 1) ? bus.gnt1 : bus.gnt0) && lat < 10);
        got_err = (p == 1) ? bus.err1 : bus.err0;
        got_mw  = bus.mem_write;
        set_req(p, 1'b0, we, a, wd);
        tick();
        got_rv = (p == 1) ? bus.rvalid1 : bus.rvalid0;
        got_rd = bus.rdata;
        tick();
    endtask

    task automatic rand_port(input int p);
        logic r, g;
        logic [31:0] a;
        r = (p == 1) ? bus.req1 : bus.req0;
        g = (p == 1) ? bus.gnt1 : bus.gnt0;
        a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(508, 515))
                                        : 32'($urandom_range(0, 15));
        if (r) begin
            if (g) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
                else
                    set_req(p, 1'b0, 1'b0, a, 32'd0);
            end
        end else if ($urandom_range(0, 9) < 3) begin
            set_req(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
        end
    endtask

    typedef struct {
        int          p;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic        exp_mw;
        logic        exp_rv;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vt [0:7];
    int          lat, ng, nv, nmr, nrv;
    logic        g_err, g_mw, g_rv;
    logic [31:0] g_rd;
    int          gord [0:3];
    int          vord [0:3];

    initial begin
        vt[0] = '{0, 1'b1, 32'd5,   32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[1] = '{0, 1'b0, 32'd5,   32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[2] = '{1, 1'b1, 32'd7,   32'h00001234, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[3] = '{0, 1'b0, 32'd7,   32'h0,        1'b0, 1'b0, 1'b1, 32'h00001234};
        vt[4] = '{1, 1'b1, 32'd511, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[5] = '{1, 1'b1, 32'd512, 32'h55AA55AA, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[6] = '{1, 1'b0, 32'd600, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vt[7] = '{1, 1'b0, 32'd511, 32'h0,        1'b0, 1'b0, 1'b1, 32'hCAFEF00D};

        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("reset_strobes", strobes(), 32'd0);
        chk("reset_mem_addr", bus.mem_addr, 32'd0);
        chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        reset = 1'b0;
        chk_on = 1'b1;
        tick();

        // Single transactions, one after another.
        for (int i = 0; i < 8; i++) begin
            do_txn(vt[i].p, vt[i].we, vt[i].addr, vt[i].wdata, lat, g_err, g_mw, g_rv, g_rd);
            chk($sformatf("vec%0d_gnt_latency", i), 32'(lat), 32'd1);
            chk($sformatf("vec%0d_err", i), {31'd0, g_err}, {31'd0, vt[i].exp_err});
            chk($sformatf("vec%0d_mem_write", i), {31'd0, g_mw}, {31'd0, vt[i].exp_mw});
            chk($sformatf("vec%0d_rvalid", i), {31'd0, g_rv}, {31'd0, vt[i].exp_rv});
            if (vt[i].exp_rv) chk($sformatf("vec%0d_rdata", i), g_rd, vt[i].exp_rdata);
        end

        // Both ports read continuously: grants and responses alternate 0,1,0,1.
        set_req(0, 1'b1, 1'b0, 32'd5, 32'd0);
        set_req(1, 1'b1, 1'b0, 32'd7, 32'd0);
        ng = 0;
        nv = 0;
        for (int t = 0; t < 30 && nv < 4; t++) begin
            tick();
            if ((bus.gnt0 || bus.gnt1) && ng < 4) begin
                gord[ng] = bus.gnt1 ? 1 : 0;
                ng++;
                if (ng == 4) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
            if ((bus.rvalid0 || bus.rvalid1) && nv < 4) begin
                vord[nv] = bus.rvalid1 ? 1 : 0;
                nv++;
            end
        end
        chk("tie_grant_count", 32'(ng), 32'd4);
        chk("tie_rvalid_count", 32'(nv), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) chk($sformatf("tie_grant%0d_port", i), 32'(gord[i]), 32'(i % 2));
            if (i < nv) chk($sformatf("tie_rvalid%0d_port", i), 32'(vord[i]), 32'(i % 2));
        end
        tick();

        // Port 0 read, request dropped right after its grant.
        set_req(0, 1'b1, 1'b0, 32'd5, 32'd0);
        nmr = 0;
        nrv = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (bus.mem_read) nmr++;
            if (bus.rvalid0) nrv++;
            if (bus.gnt0) bus.req0 = 1'b0;
        end
        chk("drop_mem_read_pulses", 32'(nmr), 32'd1);
        chk("drop_rvalid0_pulses", 32'(nrv), 32'd1);

        // Reset asserted during the response cycle of a port-0 read.
        set_req(0, 1'b1, 1'b0, 32'd7, 32'd0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.gnt0 && lat < 10);
        chk("abort_gnt0_seen", {31'd0, bus.gnt0}, 32'd1);
        bus.req0 = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_async_strobes", strobes(), 32'd0);
        chk("abort_async_mem_addr", bus.mem_addr, 32'd0);
        chk("abort_async_mem_wdata", bus.mem_wdata, 32'd0);
        chk("abort_async_rdata", bus.rdata, 32'd0);
        tick();
        chk("abort_no_rvalid0", {31'd0, bus.rvalid0}, 32'd0);
        tick();
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'd3, 32'd0);
        set_req(1, 1'b1, 1'b0, 32'd4, 32'd0);
        tick();
        chk("post_reset_tie_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd2);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (3) tick();

        // Random traffic from both ports against the reference model.
        for (int t = 0; t < 3000; t++) begin
            tick();
            rand_port(0);
            rand_port(1);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter and sequencer for the data memory. It shares the single data-memory port between port 0 (core load/store unit) and port 1 (DMA/test loader). It issues exactly one memory command per granted request and returns read data with a valid pulse. It accounts for the memory's one-cycle registered read latency and rejects out-of-range addresses without touching memory.

## Interface
- Width, 32, data and address width
- Depth, 512, number of memory words; valid addresses are 0..Depth-1
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req0 / req1  input  1  request from port 0 / port 1; held high until the matching gnt
- we0 / we1  input  1  1 = write, 0 = read; stable while req is high
- addr0 / addr1  input  Width  word address; stable while req is high
- wdata0 / wdata1  input  Width  write data; stable while req is high
- gnt0 / gnt1  output  1  one-cycle pulse: request accepted
- err0 / err1  output  1  one-cycle pulse with gnt: address out of range, request dropped
- rvalid0 / rvalid1  output  1  one-cycle pulse: rdata holds that port's read result
- rdata  output  Width  read data, shared by both ports; qualify with rvalid
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  Width  memory address
- mem_wdata  output  Width  memory write data
- mem_rdata  input  Width  memory read data, registered by memory on the edge that samples mem_read

## Operation
- FSM states: IDLE, CMD, RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise pick the winner: a lone requester wins. If both request, the port other than last_grant wins.
  - On that edge, latch the winner's we/addr/wdata and the owner, update last_grant, and compute range_err = (addr >= Depth).
  - Move to CMD.
- CMD (exactly one cycle):
  - gnt of the owner is high.
  - If range_err: err of the owner is high, mem_read and mem_write stay 0, and the next state is IDLE.
  - Else if write: mem_write = 1 and the next state is IDLE.
  - Else (read): mem_read = 1 and the next state is RESP.
  - mem_addr and mem_wdata drive the latched values during CMD. They hold their last values in all other states.
- RESP (exactly one cycle):
  - rvalid of the owner is high.
  - rdata = mem_rdata.
  - Next state is IDLE.
- Requests are not sampled in CMD or RESP. A req that stays high after its gnt is treated as a new request at the next IDLE.
- last_grant updates only on acceptance, including rejected (range_err) requests.
- Only one port is ever granted per transaction. gnt0 and gnt1 are never high together; likewise err0/err1 and rvalid0/rvalid1.

## Timing
- Reset values:
  - state IDLE, last_grant = 1 (so port 0 wins the first tie).
  - All gnt, err, rvalid, mem_read and mem_write outputs are 0.
  - mem_addr, mem_wdata and rdata are 0.
- Write: req sampled at edge N, gnt/mem_write high in cycle N..N+1, memory written at edge N+1, next sample at edge N+2. Throughput is 1 write per 2 cycles.
- Read: req sampled at edge N, gnt/mem_read high in cycle N..N+1, memory registers data at edge N+1, rvalid/rdata in cycle N+1..N+2, next sample at edge N+3. Throughput is 1 read per 3 cycles.
- Rejected request: 2 cycles, no memory strobe, no rvalid.
- gnt, err, rvalid, mem_read and mem_write are state-decoded with no combinational path from req.
- Asynchronous reset in CMD or RESP aborts the transaction immediately:
  - no rvalid is issued;
  - a write strobe cut by reset may or may not land in memory;
  - requesters re-request after reset.
- Back-to-back contention with both req held continuously: grants alternate 0, 1, 0, 1, ...

## Test plan
- Reset release, port 0 writes 0xDEADBEEF to addr 5, then reads addr 5:
  - gnt0 one cycle after req0 sampled;
  - rvalid0 two cycles after the read is sampled, rdata = 0xDEADBEEF;
  - all port-1 outputs stay 0.
- req0 and req1 rise in the same cycle, both reads, held for 4 transactions:
  - grant order is 0, 1, 0, 1;
  - each rvalid goes to the matching port.
- Port 1 writes addr 511 (accepted, mem_write pulses), then writes addr 512:
  - gnt1 and err1 pulse together;
  - mem_write stays 0 and memory is unchanged;
  - the next tie goes to port 0.
- Port 0 single read with req0 dropped right after gnt0: exactly one mem_read pulse and one rvalid0.
- Assert reset during RESP of a port-0 read:
  - rvalid0 never pulses;
  - all outputs go to 0 asynchronously;
  - after release the state is IDLE and port 0 wins a tie.
- Write then read to the same address from different ports (port 1 writes 0x1234 at addr 7, port 0 reads addr 7): rdata = 0x1234 with rvalid0.
